// File: rtl/tick_period_monitor.sv
// Tick period monitor: measures the distance between consecutive single-cycle ticks and
// tracks lock/fault status against the expected period within a tolerance.
module tick_period_monitor #(
    parameter int unsigned P        = 7501,
    parameter int unsigned TOL      = 2,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned WBITS    = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             err_in,
    input  logic             clr,
    output logic             locked,
    output logic             fault,
    output logic             sticky_err,
    output logic [WBITS-1:0] ival,
    output logic             ival_vld,
    output logic [7:0]       fault_cnt
);

    typedef enum logic [1:0] {StIdle, StAcq, StLock, StFault} state_e;

    localparam logic [WBITS-1:0] LoLim   = WBITS'(P - TOL);
    localparam logic [WBITS-1:0] HiLim   = WBITS'(P + TOL);
    localparam logic [WBITS-1:0] ToLim   = WBITS'(P + TOL + 1);
    localparam logic [3:0]       LockTgt = 4'(LOCK_CNT);

    state_e           state_q, state_d;
    logic [WBITS-1:0] cnt_q, cnt_d;
    logic [3:0]       run_q, run_d;
    logic [WBITS-1:0] ival_q;
    logic             ival_vld_q;
    logic             sticky_q;
    logic [7:0]       fault_cnt_q;

    logic good;
    logic timeout;
    logic fault_entry;
    logic measured;

    assign good     = (cnt_q >= LoLim) && (cnt_q <= HiLim);
    // A tick landing on the timeout count is treated as a late tick instead.
    assign timeout  = !tick && (cnt_q == ToLim) && ((state_q == StAcq) || (state_q == StLock));
    // The first tick after IDLE has no preceding tick, so it carries no interval.
    assign measured = tick && (state_q != StIdle);

    always_comb begin
        cnt_d = cnt_q;
        if (tick) begin
            cnt_d = WBITS'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + WBITS'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StAcq;
                    run_d   = '0;
                end
            end
            StAcq: begin
                if (tick) begin
                    if (good) begin
                        run_d = run_q + 4'd1;
                        if (run_q + 4'd1 == LockTgt) begin
                            state_d = StLock;
                        end
                    end else begin
                        run_d = '0;
                    end
                end else if (timeout) begin
                    state_d = StIdle;
                    run_d   = '0;
                end
            end
            StLock: begin
                if ((tick && !good) || timeout) begin
                    state_d = StFault;
                end
            end
            StFault: begin
                if (tick) begin
                    state_d = StAcq;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
                run_d   = '0;
            end
        endcase
        if (err_in) begin
            state_d = StFault;
            run_d   = '0;
        end
    end

    assign fault_entry = (state_d == StFault) && (state_q != StFault);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            run_q       <= '0;
            ival_q      <= '0;
            ival_vld_q  <= 1'b0;
            sticky_q    <= 1'b0;
            fault_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            run_q      <= run_d;
            ival_vld_q <= measured;
            if (measured) begin
                ival_q <= cnt_q;
            end
            // Entry wins over a simultaneous clear.
            if (fault_entry) begin
                sticky_q <= 1'b1;
                if (fault_cnt_q != 8'hff) begin
                    fault_cnt_q <= fault_cnt_q + 8'd1;
                end
            end else if (clr) begin
                sticky_q    <= 1'b0;
                fault_cnt_q <= '0;
            end
        end
    end

    assign locked     = (state_q == StLock);
    assign fault      = (state_q == StFault);
    assign sticky_err = sticky_q;
    assign ival       = ival_q;
    assign ival_vld   = ival_vld_q;
    assign fault_cnt  = fault_cnt_q;

    a_lock_fault_excl: assert property (@(posedge clk) disable iff (rst) !(locked && fault));

`ifdef FORMAL
    // Once the environment settles (no reset, no upstream error, every interval good),
    // the monitor must end up permanently locked.
    m_env_settles: assume property (@(posedge clk)
        s_eventually always (!rst && !err_in && (cnt_q <= HiLim) && (!tick || good)));
    a_eventually_locked: assert property (@(posedge clk) s_eventually always locked);
`endif

endmodule

// File: tb/tb_tick_period_monitor.sv
// Directed bench for tick_period_monitor, run with a shortened period so the full
// lock/fault/saturation sequence fits in a few thousand cycles.
module tb_tick_period_monitor;

    localparam int unsigned P     = 101;
    localparam int unsigned TOL   = 2;
    localparam int unsigned WBITS = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             tick;
    logic             err_in;
    logic             clr;
    logic             locked;
    logic             fault;
    logic             sticky_err;
    logic [WBITS-1:0] ival;
    logic             ival_vld;
    logic [7:0]       fault_cnt;

    int checks   = 0;
    int failures = 0;

    tick_period_monitor #(
        .P        (P),
        .TOL      (TOL),
        .LOCK_CNT (3),
        .WBITS    (WBITS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .err_in     (err_in),
        .clr        (clr),
        .locked     (locked),
        .fault      (fault),
        .sticky_err (sticky_err),
        .ival       (ival),
        .ival_vld   (ival_vld),
        .fault_cnt  (fault_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are checked at that same point.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Tick whose measured interval is `gap` when counted from the previous tick.
    task automatic send_tick(input int gap, input bit err);
        tick = 1'b0;
        repeat (gap - 1) cyc();
        tick   = 1'b1;
        err_in = err;
        cyc();
        tick   = 1'b0;
        err_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_locked"}, 32'(locked), 0);
        check_eq({tag, "_fault"}, 32'(fault), 0);
        check_eq({tag, "_sticky"}, 32'(sticky_err), 0);
        check_eq({tag, "_ival"}, 32'(ival), 0);
        check_eq({tag, "_vld"}, 32'(ival_vld), 0);
        check_eq({tag, "_fcnt"}, 32'(fault_cnt), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; tick = 1'b0; err_in = 1'b0; clr = 1'b0;
        repeat (3) cyc();
        check_all_zero("reset");
        rst = 1'b0;

        // Acquire and lock with exact-period ticks
        send_tick(5, 1'b0);
        check_eq("first_tick_no_vld", 32'(ival_vld), 0);
        send_tick(P, 1'b0);
        check_eq("tick2_ival", 32'(ival), 101);
        check_eq("tick2_vld", 32'(ival_vld), 1);
        cyc();
        check_eq("vld_one_cycle", 32'(ival_vld), 0);
        send_tick(P - 1, 1'b0);
        check_eq("tick3_not_locked", 32'(locked), 0);
        send_tick(P, 1'b0);
        check_eq("tick4_locked", 32'(locked), 1);
        check_eq("tick4_fcnt", 32'(fault_cnt), 0);

        // Tolerance edges while locked, then an early tick
        send_tick(P + TOL, 1'b0);
        check_eq("hi_edge_locked", 32'(locked), 1);
        check_eq("hi_edge_ival", 32'(ival), 103);
        send_tick(P - TOL, 1'b0);
        check_eq("lo_edge_locked", 32'(locked), 1);
        check_eq("lo_edge_ival", 32'(ival), 99);
        send_tick(P - TOL - 1, 1'b0);
        check_eq("early_fault", 32'(fault), 1);
        check_eq("early_unlocked", 32'(locked), 0);
        check_eq("early_sticky", 32'(sticky_err), 1);
        check_eq("early_fcnt", 32'(fault_cnt), 1);
        check_eq("early_ival", 32'(ival), 98);

        // Relock, then let ticks stop
        send_tick(7, 1'b0);
        check_eq("fault_tick_acq", 32'(fault), 0);
        check_eq("fault_tick_ival", 32'(ival), 7);
        repeat (3) send_tick(P, 1'b0);
        check_eq("relock1", 32'(locked), 1);
        tick = 1'b0;
        repeat (P + TOL) cyc();
        check_eq("pre_timeout_locked", 32'(locked), 1);
        check_eq("pre_timeout_fault", 32'(fault), 0);
        cyc();
        check_eq("timeout_fault", 32'(fault), 1);
        check_eq("timeout_unlocked", 32'(locked), 0);
        check_eq("timeout_fcnt", 32'(fault_cnt), 2);
        check_eq("timeout_sticky", 32'(sticky_err), 1);

        // Long gap in FAULT: no timeout there, counter saturates, next tick is late
        repeat (300) cyc();
        check_eq("fault_hold", 32'(fault), 1);
        check_eq("fault_hold_fcnt", 32'(fault_cnt), 2);
        send_tick(1, 1'b0);
        check_eq("sat_ival", 32'(ival), 255);
        check_eq("sat_vld", 32'(ival_vld), 1);
        check_eq("sat_acq", 32'(fault), 0);
        repeat (2) send_tick(P, 1'b0);
        check_eq("relock2_pending", 32'(locked), 0);
        send_tick(P, 1'b0);
        check_eq("relock2", 32'(locked), 1);
        check_eq("relock2_sticky", 32'(sticky_err), 1);

        // Clear while locked, then err_in coincident with a good tick
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check_eq("clr_sticky", 32'(sticky_err), 0);
        check_eq("clr_fcnt", 32'(fault_cnt), 0);
        check_eq("clr_locked", 32'(locked), 1);
        send_tick(P - 1, 1'b1);
        check_eq("err_fault", 32'(fault), 1);
        check_eq("err_unlocked", 32'(locked), 0);
        check_eq("err_fcnt", 32'(fault_cnt), 1);
        check_eq("err_ival", 32'(ival), 101);

        // Early tick in ACQ restarts the good-interval run; then reset mid-ACQ at run=2
        send_tick(3, 1'b0);
        send_tick(P, 1'b0);
        send_tick(P - TOL - 1, 1'b0);
        check_eq("acq_early_ival", 32'(ival), 98);
        send_tick(P, 1'b0);
        send_tick(P, 1'b0);
        check_eq("acq_run_restart", 32'(locked), 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_all_zero("midacq_rst");
        send_tick(20, 1'b0);
        check_eq("post_rst_vld", 32'(ival_vld), 0);
        check_eq("post_rst_ival", 32'(ival), 0);

        // Tick on the timeout count is late; one cycle later the ACQ timeout wins
        send_tick(P + TOL + 1, 1'b0);
        check_eq("late_edge_vld", 32'(ival_vld), 1);
        check_eq("late_edge_ival", 32'(ival), 104);
        check_eq("late_edge_fault", 32'(fault), 0);
        send_tick(P + TOL + 2, 1'b0);
        check_eq("acq_timeout_idle_vld", 32'(ival_vld), 0);
        check_eq("acq_timeout_ival", 32'(ival), 104);

        // clr coincident with FAULT entry, then a clr on its own
        err_in = 1'b1; clr = 1'b1;
        cyc();
        err_in = 1'b0; clr = 1'b0;
        check_eq("clr_entry_fault", 32'(fault), 1);
        check_eq("clr_entry_sticky", 32'(sticky_err), 1);
        check_eq("clr_entry_fcnt", 32'(fault_cnt), 1);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        check_eq("clr_after_sticky", 32'(sticky_err), 0);
        check_eq("clr_after_fcnt", 32'(fault_cnt), 0);

        // err_in in FAULT overrides a tick and is not a new entry
        err_in = 1'b1; tick = 1'b1;
        cyc();
        err_in = 1'b0; tick = 1'b0;
        check_eq("err_hold_fault", 32'(fault), 1);
        check_eq("err_hold_fcnt", 32'(fault_cnt), 0);
        check_eq("err_hold_vld", 32'(ival_vld), 1);

        // fault_cnt saturation
        for (int i = 0; i < 256; i++) begin
            tick = 1'b1;
            cyc();
            tick   = 1'b0;
            err_in = 1'b1;
            cyc();
            err_in = 1'b0;
            if (i == 253) check_eq("fcnt_254", 32'(fault_cnt), 254);
        end
        check_eq("fcnt_sat", 32'(fault_cnt), 255);
        check_eq("fcnt_sat_fault", 32'(fault), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tick_period_monitor.md
# tick_period_monitor

Downstream consumer of a periodic single-cycle tick (the `sig` pulse of the delay counter). Measures the cycle distance between consecutive ticks, compares it against the expected period within a tolerance, and runs a lock/fault state machine. Its outputs are the locked/fault status and interval telemetry used by the safety and liveness properties of the timing path.

## Interface
- `P`, 7501: expected tick period in cycles; the upstream counter cycles 0..N, so P = N+1.
- `TOL`, 2: allowed ± deviation from P in cycles.
- `LOCK_CNT`, 3: consecutive good intervals required to lock (1..15).
- `WBITS`, 14: interval counter width; must satisfy 2^WBITS − 1 > P+TOL+1.

Ports:
- `clk`  in  1  clock; everything sampled on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `tick`  in  1  single-cycle period pulse from the upstream counter.
- `err_in`  in  1  upstream overrun indication.
- `clr`  in  1  clears `sticky_err` and `fault_cnt`.
- `locked`  out  1  high while the state is LOCK.
- `fault`  out  1  high while the state is FAULT.
- `sticky_err`  out  1  set on every entry to FAULT; cleared only by `clr` or `rst`.
- `ival`  out  WBITS  last measured interval.
- `ival_vld`  out  1  one-cycle pulse when `ival` updates.
- `fault_cnt`  out  8  count of FAULT entries; saturates at 255.

## Operation
- Interval counter `cnt`:
  - On a tick cycle, set to 1 at the next edge.
  - Otherwise, increment each cycle, saturating at all-ones.
  - The interval for a tick is the value of `cnt` in that tick cycle, which equals the cycles since the previous tick.
- Classification on a tick cycle:
  - good if P−TOL ≤ cnt ≤ P+TOL.
  - early if cnt < P−TOL.
  - late if cnt > P+TOL.
- Timeout: `cnt` equals P+TOL+1 in a non-tick cycle, in state ACQ or LOCK.
- Every tick outside IDLE loads `ival` with `cnt` and pulses `ival_vld`. The first tick after IDLE does not, because it has no measured interval.
- States: IDLE, ACQ, LOCK, FAULT. `run` is a 4-bit good-interval counter.
  - IDLE: on tick, go to ACQ with run=0.
  - ACQ, good tick: run+1. If run+1 = LOCK_CNT, go to LOCK.
  - ACQ, early or late tick: run=0, stay in ACQ; the interval restarts from this tick.
  - ACQ, timeout: go to IDLE with run=0.
  - LOCK, good tick: stay in LOCK.
  - LOCK, early tick, late tick or timeout: go to FAULT.
  - FAULT: on tick, go to ACQ with run=0. No timeout applies in FAULT.
- `err_in` high in any state except FAULT forces FAULT, overriding any tick or timeout in the same cycle. Asserted while already in FAULT, it holds FAULT and also overrides a tick in that cycle.
- Entry to FAULT from another state sets `sticky_err` and increments `fault_cnt` (saturating). Entry happens only on the transition, never while held in FAULT.
- `clr` is ignored in a cycle that enters FAULT: set and increment win. Otherwise `clr` zeroes both `sticky_err` and `fault_cnt`.
- Formal property carried in the module:
  - Assumption: eventually `rst` is always low, `err_in` is always low, and ticks arrive with good intervals.
  - Required result: eventually `locked` is always high, written as s_eventually always.
- Safety property: `locked` and `fault` are never high together.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `cnt`, `run`, `ival` = 0; `ival_vld`, `locked`, `fault`, `sticky_err` = 0; `fault_cnt` = 0.
- `rst` overrides every other input in the same cycle, including when asserted mid-ACQ or mid-LOCK.
- `locked` rises one cycle after the tick that completes the LOCK_CNT-th good interval.
- `fault` rises one cycle after the triggering tick, timeout cycle or `err_in` cycle.
- `ival` and `ival_vld` update one cycle after the tick.
- A tick coinciding with cnt = P+TOL+1 is classified as a late tick, not as a timeout. The resulting state is the same.
- When `cnt` saturates (long gap while in IDLE or FAULT), the next tick classifies as late. In FAULT this is still a tick, so the state goes to ACQ.

## Test plan
- Reset, then ticks every 7501 cycles: the 2nd tick gives `ival`=7501 with `ival_vld` pulsing. `locked`=1 one cycle after the 4th tick; `fault_cnt`=0.
- While locked, a tick after 7499 cycles keeps `locked`=1 and sets `ival`=7499. A later tick after 7498 cycles gives `fault`=1 and `locked`=0 the next cycle, with `sticky_err`=1 and `fault_cnt`=1.
- While locked, ticks stop: at cnt=7504 with no tick, `fault`=1 the next cycle. Resumed good ticks give ACQ, and `locked`=1 after 3 further good intervals; `sticky_err` stays 1.
- While locked, a one-cycle `err_in` coincident with a good tick gives FAULT with `fault_cnt`=1, and `ival` still updates to 7501.
- While in ACQ with run=2, `rst`=1: the next cycle has all outputs zero and state IDLE. The following tick does not pulse `ival_vld`.
- `clr` in the same cycle as a FAULT entry leaves `sticky_err`=1 and `fault_cnt`=1. A `clr` one cycle later zeroes both. 256 FAULT entries leave `fault_cnt` at 255.
